cordic_iter_core: RTL and testbench

Parametrised iterative CORDIC engine computing sine/cosine (rotation mode) and, optionally, magnitude/phase (vectoring mode) over a start/done handshake. One micro-rotation per clock with arithmetic shifts and guard bits. It replaces the fixed 5-bit sequencer in the TinyTapeout CORDIC tile and is instantiated behind the tile's I/O muxing.

---
 rtl/cordic_iter_core_if.sv | 28 ++
 rtl/cordic_iter_core.sv | 197 +++++++++++++++++++
 tb/tb_cordic_iter_core.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_core_if.sv
// Start/done handshake and operand/result bus for cordic_iter_core.
// The master drives the request side (start, mode, operands). The slave
// (the CORDIC core) drives status and results.
interface cordic_iter_core_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic                    valid;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;

  modport master (
    output start, mode, x_in, y_in, z_in,
    input  busy, done, valid, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in,
    output busy, done, valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: one micro-rotation per clock.
// Rotation mode produces cos/sin of z_in, scaled by the pre-applied gain K.
// Vectoring mode produces magnitude and phase. It is compiled in only when
// CORDIC_VECTOR_EN is defined. Without that macro, mode/x_in/y_in are
// ignored and every operation is rotation.
// Internal x/y/z carry GUARD extra bits at both ends. Outputs are rounded
// and then saturated back to WIDTH.
module cordic_iter_core #(
  parameter int WIDTH = 8,
  parameter int ITERS = 6,
  parameter int GUARD = 2
) (
  input  logic              clk,
  input  logic              reset,
  cordic_iter_core_if.slave bus
);

  localparam int IW   = WIDTH + 2 * GUARD;
  localparam int IT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  // Gain 0.607253 held at 2^24 scale, then rounded to the x/y format 2^(WIDTH-2).
  localparam int K_VAL = (10188014 + (1 << (25 - WIDTH))) >>> (26 - WIDTH);
  localparam logic signed [IW-1:0] K_INT = IW'(K_VAL << GUARD);

  localparam logic signed [IW:0] RND_ADD = (IW+1)'((1 << GUARD) >> 1);
  localparam logic signed [IW:0] SAT_HI  = (IW+1)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IW:0] SAT_LO  = (IW+1)'(-(1 << (WIDTH - 1)));

  // atan(2^-i)/pi at 2^24 scale. For i >= 15 the value is below any legal WIDTH's LSB.
  function automatic int atan_frac(input int i);
    case (i)
      0:       return 4194304;
      1:       return 2476042;
      2:       return 1308273;
      3:       return 664100;
      4:       return 333333;
      5:       return 166832;
      6:       return 83436;
      7:       return 41721;
      8:       return 20861;
      9:       return 10430;
      10:      return 5215;
      11:      return 2608;
      12:      return 1304;
      13:      return 652;
      14:      return 326;
      default: return 0;
    endcase
  endfunction

  // Build the arctangent table at elaboration time.
  // Each entry is rounded to the z format 2^(WIDTH-1) per 180 deg, then moved under the guard bits.
  function automatic logic [ITERS*IW-1:0] build_rom();
    logic [ITERS*IW-1:0] rom;
    int                  e;
    rom = '0;
    for (int i = 0; i < ITERS; i++) begin
      e = (atan_frac(i) + (1 << (24 - WIDTH))) >>> (25 - WIDTH);
      rom[i*IW +: IW] = IW'(e << GUARD);
    end
    return rom;
  endfunction

  localparam logic [ITERS*IW-1:0] ATAN_ROM = build_rom();

  // Drop the guard LSBs with round-half-up, then clamp to the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] to_out(input logic signed [IW-1:0] v);
    logic signed [IW:0] w;
    w = ((IW+1)'(v) + RND_ADD) >>> GUARD;
    if (w > SAT_HI)      to_out = {1'b0, {(WIDTH-1){1'b1}}};
    else if (w < SAT_LO) to_out = {1'b1, {(WIDTH-1){1'b0}}};
    else                 to_out = w[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_last;
  logic [IT_W-1:0]         r_iter;
  logic signed [IW-1:0]    r_x, r_y, r_z;
  logic signed [IW-1:0]    w_x_sh, w_y_sh, w_atan;
  logic signed [IW-1:0]    w_x_nxt, w_y_nxt, w_z_nxt;
  logic                    w_d_pos;
  logic                    w_vec;
  logic                    r_valid;
  logic signed [WIDTH-1:0] r_x_out, r_y_out, r_z_out;

`ifdef CORDIC_VECTOR_EN
  logic r_mode;
  assign w_vec = r_mode;
`else
  assign w_vec = 1'b0;
`endif

  assign w_last = (r_iter == IT_W'(ITERS - 1));

  // State register. Reset has priority, so a start during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave CALC after the last step, DONE lasts one cycle.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it unassigned and infers a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_CALC;
      end
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One micro-rotation. d comes from the sign of z (rotation) or the sign of y (vectoring).
  always_comb begin
    w_x_sh  = r_x >>> r_iter;
    w_y_sh  = r_y >>> r_iter;
    w_atan  = ATAN_ROM[int'(r_iter)*IW +: IW];
    w_d_pos = w_vec ? r_y[IW-1] : ~r_z[IW-1];
    if (w_d_pos) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  // Datapath: load on accept, step in CALC, register rounded results on the last step.
  always_ff @(posedge clk) begin
    // NOTE: working registers are reset along with the outputs. That makes an
    // aborted operation leave no stale state, and the cost is only a handful of flops.
    if (reset) begin
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_valid <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
`ifdef CORDIC_VECTOR_EN
      r_mode  <= 1'b0;
`endif
    end else if (w_accept) begin
      // NOTE: non-blocking assignments here so that every register in this block updates from pre-edge values.
      r_iter  <= '0;
      r_valid <= 1'b0;
      r_z     <= IW'(bus.z_in) <<< GUARD;
`ifdef CORDIC_VECTOR_EN
      r_mode  <= bus.mode;
      if (bus.mode) begin
        r_x <= IW'(bus.x_in) <<< GUARD;
        r_y <= IW'(bus.y_in) <<< GUARD;
      end else begin
        r_x <= K_INT;
        r_y <= '0;
      end
`else
      r_x     <= K_INT;
      r_y     <= '0;
`endif
    end else if (r_state == S_CALC) begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_z    <= w_z_nxt;
      r_iter <= r_iter + IT_W'(1);
      if (w_last) begin
        r_x_out <= to_out(w_x_nxt);
        r_y_out <= to_out(w_y_nxt);
        r_z_out <= to_out(w_z_nxt);
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.busy  = (r_state == S_CALC);
  assign bus.done  = (r_state == S_DONE);
  assign bus.valid = r_valid;
  assign bus.x_out = r_x_out;
  assign bus.y_out = r_y_out;
  assign bus.z_out = r_z_out;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core at WIDTH=8, ITERS=6, GUARD=2.
// A behavioural model computes each result from the number-format rules.
// It uses its own real-valued atan table and gain. A timing model tracks
// busy/done/valid. One negedge process compares the DUT against both every cycle.
module tb_cordic_iter_core;
  localparam int W = 8;
  localparam int N = 6;
  localparam int G = 2;
  localparam real PI = 3.14159265358979;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  cordic_iter_core_if #(.WIDTH(W)) bus ();

  cordic_iter_core #(.WIDTH(W), .ITERS(N), .GUARD(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d +/- %0d", name, $time, act, exp, tol);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int atan_ref(input int i);
    return int'($floor($atan(2.0 ** (-i)) * (2.0 ** (W - 1)) / PI + 0.5));
  endfunction

  function automatic int k_ref();
    return int'($floor(0.607253 * (2.0 ** (W - 2)) + 0.5));
  endfunction

  function automatic int out_ref(input int v);
    int r;
    r = (v + ((1 << G) >> 1)) >>> G;
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
    return r;
  endfunction

  function automatic bit vec_ref(input logic m);
`ifdef CORDIC_VECTOR_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_op(input bit vec, input int xi, input int yi, input int zi,
                          output int xo, output int yo, output int zo);
    int x, y, z, xn, d;
    if (vec) begin
      x = xi <<< G;
      y = yi <<< G;
    end else begin
      x = k_ref() <<< G;
      y = 0;
    end
    z = zi <<< G;
    for (int i = 0; i < N; i++) begin
      if (vec) d = (y < 0) ? 1 : -1;
      else     d = (z >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      y  = y + d * (x >>> i);
      x  = xn;
      z  = z - d * (atan_ref(i) <<< G);
    end
    xo = out_ref(x);
    yo = out_ref(y);
    zo = out_ref(z);
  endtask

  // Timing model. m_cyc is -1 when idle, or the number of edges since the accept edge.
  int m_cyc = -1;
  bit m_valid = 1'b0;
  int m_x = 0, m_y = 0, m_z = 0;
  int p_x = 0, p_y = 0, p_z = 0;

  always @(posedge clk) begin : model_blk
    int tx, ty, tz;
    if (reset) begin
      m_cyc   <= -1;
      m_valid <= 1'b0;
      m_x     <= 0;
      m_y     <= 0;
      m_z     <= 0;
    end else if (m_cyc < 0) begin
      if (bus.start) begin
        model_op(vec_ref(bus.mode), int'(bus.x_in), int'(bus.y_in), int'(bus.z_in), tx, ty, tz);
        p_x     <= tx;
        p_y     <= ty;
        p_z     <= tz;
        m_cyc   <= 0;
        m_valid <= 1'b0;
      end
    end else if (m_cyc == N) begin
      m_cyc <= -1;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == N) begin
        m_x     <= p_x;
        m_y     <= p_y;
        m_z     <= p_z;
        m_valid <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy",  int'(bus.busy),  int'(m_cyc >= 0 && m_cyc < N));
      check("done",  int'(bus.done),  int'(m_cyc == N));
      check("valid", int'(bus.valid), int'(m_valid));
      check("x_out", int'(bus.x_out), m_x);
      check("y_out", int'(bus.y_out), m_y);
      check("z_out", int'(bus.z_out), m_z);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int rx, ry, rz;

  // Issue one request and wait (bounded) for done. Checks that done follows the accept edge by ITERS edges.
  task automatic run_op(input logic m, input int xi, input int yi, input int zi,
                        output int xo, output int yo, output int zo);
    int k;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.x_in  = W'(xi);
    bus.y_in  = W'(yi);
    bus.z_in  = W'(zi);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = W'($urandom);
    bus.y_in  = W'($urandom);
    bus.z_in  = W'($urandom);
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.done || k >= N + 8) break;
      @(posedge clk);
      k++;
    end
    check("done_latency", k, N);
    xo = int'(bus.x_out);
    yo = int'(bus.y_out);
    zo = int'(bus.z_out);
  endtask

  initial begin : stim
    int dc;
    int ex, ey;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.z_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_x_out", int'(bus.x_out), 0);
    reset = 1'b0;

    // Pin the model with hand-computed constants.
    check("ref_k", k_ref(), 39);
    check("ref_atan0", atan_ref(0), 32);
    check("ref_atan1", atan_ref(1), 19);
    check("ref_atan2", atan_ref(2), 10);
    check("ref_atan3", atan_ref(3), 5);
    check("ref_atan4", atan_ref(4), 3);
    check("ref_atan5", atan_ref(5), 1);
    model_op(1'b0, 0, 0, -32, rx, ry, rz);
    check("ref_m45_x", rx, 45);
    check("ref_m45_y", ry, -45);

    // Rotation literals.
    run_op(1'b0, 0, 0, 0, rx, ry, rz);
    check_tol("rot0_x", rx, 64, 2);
    check_tol("rot0_y", ry, 0, 2);
    check_tol("rot0_z", rz, 0, 2);
    run_op(1'b0, 0, 0, 64, rx, ry, rz);
    check_tol("rot90_x", rx, 0, 2);
    check_tol("rot90_y", ry, 64, 2);
    run_op(1'b0, 0, 0, -32, rx, ry, rz);
    check_tol("rotm45_x", rx, 45, 2);
    check_tol("rotm45_y", ry, -45, 2);

`ifdef CORDIC_VECTOR_EN
    run_op(1'b1, 32, 32, 0, rx, ry, rz);
    check_tol("vec_x", rx, 75, 2);
    check_tol("vec_y", ry, 0, 2);
    check_tol("vec_z", rz, 32, 2);
`else
    run_op(1'b1, 32, 32, 0, rx, ry, rz);
    check_tol("novec_x", rx, 64, 2);
    check_tol("novec_y", ry, 0, 2);
`endif

    // Sweep against real sin/cos. Six quantised micro-rotations can leave
    // roughly 3 angle LSB of residual, so the bound allows 5 output LSB.
    for (int z = -64; z <= 64; z++) begin
      run_op(1'b0, 0, 0, z, rx, ry, rz);
      ex = int'($floor(64.0 * $cos(real'(z) * PI / 128.0) + 0.5));
      ey = int'($floor(64.0 * $sin(real'(z) * PI / 128.0) + 0.5));
      check_tol("sweep_x", rx, ex, 5);
      check_tol("sweep_y", ry, ey, 5);
    end

    // Start held high through the whole operation gives exactly one done.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.z_in  = W'(20);
    dc = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (bus.done) dc++;
      @(posedge clk);
    end
    #1;
    bus.start = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    check("held_start_dones", dc, 1);

    // Reset after three steps aborts the operation. A start during reset is ignored.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.z_in  = W'(40);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    check("abort_busy",  int'(bus.busy),  0);
    check("abort_done",  int'(bus.done),  0);
    check("abort_valid", int'(bus.valid), 0);
    check("abort_x_out", int'(bus.x_out), 0);
    check("abort_y_out", int'(bus.y_out), 0);
    run_op(1'b0, 0, 0, 0, rx, ry, rz);
    check_tol("after_abort_x", rx, 64, 2);

    // Random operations. Rotation angles stay inside +/-90 deg, and vectoring keeps x_in >= 0.
    repeat (40) begin
      logic m;
      int   xi, yi, zi;
      m  = 1'($urandom);
      zi = int'($urandom_range(128)) - 64;
      xi = int'($urandom_range(127));
      yi = int'($urandom_range(255)) - 128;
      run_op(m, xi, yi, zi, rx, ry, rz);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
